// File: rtl/posit_result_checker_pkg.sv
// Shared definitions for the posit result checker: state encoding,
// counter width, the 32-bit NaR pattern and a saturating increment helper.
package posit_defines;

    localparam int          CHECK_CNT_WIDTH = 32;
    localparam logic [31:0] POSIT_NAR_32    = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } checker_state_t;

    // Statistics counters stick at all-ones rather than wrapping
    function automatic logic [CHECK_CNT_WIDTH-1:0] sat_inc(
        input logic [CHECK_CNT_WIDTH-1:0] value
    );
        return (value == {CHECK_CNT_WIDTH{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/posit_result_checker_if.sv
// Handshake bundle between the posit pipeline / golden source (master)
// and the result checker (slave).
interface posit_result_checker_if #(
    parameter int N = 32
) ();

    logic         exp_valid;
    logic [N-1:0] exp_data;
    logic         exp_ready;
    logic         res_valid;
    logic [N-1:0] res_data;

    modport master (
        output exp_valid,
        output exp_data,
        input  exp_ready,
        output res_valid,
        output res_data
    );

    modport slave (
        input  exp_valid,
        input  exp_data,
        output exp_ready,
        input  res_valid,
        input  res_data
    );

endinterface

// File: rtl/posit_result_checker_fifo.sv
// Expected-value FIFO for the result checker: DEPTH x N storage with
// registered read/write pointers carrying an extra wrap bit so that full
// and empty can be told apart. clr has priority over push and pop.
module posit_check_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [N-1:0] mem_q [DEPTH];
    logic [N-1:0] mem_d [DEPTH];

    // Same index with opposite wrap bits means the writer is a full lap ahead
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rdata = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer and storage updates; pushes into a full FIFO are refused here too
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Pointers reset to the empty condition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/posit_result_checker.sv
// Posit result checker: queues golden values, pops one per pipeline result,
// compares bit patterns with a tolerance and keeps pass/fail statistics.
// Optional macro POSIT_CHECK_FIRST_ERR_EN builds capture registers for the
// first failing compare; without it the first_err outputs are tied to 0.
module posit_result_checker
    import posit_defines::*;
#(
    parameter int          N     = 32,
    parameter int          DEPTH = 16,
    parameter int unsigned TOL   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    posit_result_checker_if.slave      bus,
    output logic [CHECK_CNT_WIDTH-1:0] match_count,
    output logic [CHECK_CNT_WIDTH-1:0] err_count,
    output logic [N-1:0]               max_diff,
    output logic                       mismatch,
    output logic                       underflow,
    output logic                       overflow,
    output logic                       done,
    output logic [N-1:0]               first_err_exp,
    output logic [N-1:0]               first_err_res,
    output logic [31:0]                first_err_idx
);

    localparam logic [N-1:0] NAR   = (N == 32) ? N'(POSIT_NAR_32) : {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] TOL_N = N'(TOL);

    checker_state_t state_q, state_d;

    logic         exp_ready_int;
    logic         accept_res;
    logic         fifo_full;
    logic         fifo_empty;
    logic [N-1:0] fifo_rdata;
    logic         push;
    logic         pop;

    logic         exp_nar;
    logic         res_nar;
    logic [N-1:0] diff;
    logic         is_match;

    logic [CHECK_CNT_WIDTH-1:0] match_count_q, match_count_d;
    logic [CHECK_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [N-1:0]               max_diff_q, max_diff_d;
    logic                       mismatch_q, mismatch_d;
    logic                       underflow_q, underflow_d;
    logic                       overflow_q, overflow_d;

    posit_check_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .push  (push),
        .pop   (pop),
        .wdata (bus.exp_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Run-control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start re-arms only from IDLE/DONE, stop only acts in RUN
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (stop)  state_d = DRAIN;
                DRAIN:   if (fifo_empty && !bus.res_valid) state_d = DONE;
                DONE:    if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // State-decoded outputs and the push/pop strobes
    always_comb begin
        exp_ready_int = (state_q == RUN) && !fifo_full;
        accept_res    = (state_q == RUN) || (state_q == DRAIN);
        done          = (state_q == DONE);
        push          = bus.exp_valid && exp_ready_int;
        pop           = bus.res_valid && accept_res && !fifo_empty;
    end

    assign bus.exp_ready = exp_ready_int;

    // Absolute bit-pattern distance; NaR only agrees with NaR
    always_comb begin
        exp_nar  = (fifo_rdata == NAR);
        res_nar  = (bus.res_data == NAR);
        diff     = '0;
        is_match = 1'b0;
        if (exp_nar || res_nar) begin
            is_match = exp_nar && res_nar;
            diff     = is_match ? '0 : '1;
        end else begin
            diff     = (fifo_rdata > bus.res_data) ? fifo_rdata - bus.res_data
                                                   : bus.res_data - fifo_rdata;
            is_match = (diff <= TOL_N);
        end
    end

    // Statistics update on each accepted result; clear wipes everything
    always_comb begin
        match_count_d = match_count_q;
        err_count_d   = err_count_q;
        max_diff_d    = max_diff_q;
        mismatch_d    = 1'b0;
        underflow_d   = underflow_q;
        overflow_d    = overflow_q;
        if (clear) begin
            match_count_d = '0;
            err_count_d   = '0;
            max_diff_d    = '0;
            underflow_d   = 1'b0;
            overflow_d    = 1'b0;
        end else begin
            if (pop) begin
                if (is_match) begin
                    match_count_d = sat_inc(match_count_q);
                end else begin
                    err_count_d = sat_inc(err_count_q);
                    mismatch_d  = 1'b1;
                end
                if (diff > max_diff_q) begin
                    max_diff_d = diff;
                end
            end
            if (bus.res_valid && accept_res && fifo_empty) begin
                underflow_d = 1'b1;
            end
            if (bus.exp_valid && (state_q == RUN) && fifo_full) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_count_q <= '0;
            err_count_q   <= '0;
            max_diff_q    <= '0;
            mismatch_q    <= 1'b0;
            underflow_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            match_count_q <= match_count_d;
            err_count_q   <= err_count_d;
            max_diff_q    <= max_diff_d;
            mismatch_q    <= mismatch_d;
            underflow_q   <= underflow_d;
            overflow_q    <= overflow_d;
        end
    end

    assign match_count = match_count_q;
    assign err_count   = err_count_q;
    assign max_diff    = max_diff_q;
    assign mismatch    = mismatch_q;
    assign underflow   = underflow_q;
    assign overflow    = overflow_q;

`ifdef POSIT_CHECK_FIRST_ERR_EN
    logic [31:0]  cmp_idx_q, cmp_idx_d;
    logic         fe_valid_q, fe_valid_d;
    logic [N-1:0] fe_exp_q, fe_exp_d;
    logic [N-1:0] fe_res_q, fe_res_d;
    logic [31:0]  fe_idx_q, fe_idx_d;

    // Count every compare and latch the first failing one only
    always_comb begin
        cmp_idx_d  = cmp_idx_q;
        fe_valid_d = fe_valid_q;
        fe_exp_d   = fe_exp_q;
        fe_res_d   = fe_res_q;
        fe_idx_d   = fe_idx_q;
        if (clear) begin
            cmp_idx_d  = '0;
            fe_valid_d = 1'b0;
            fe_exp_d   = '0;
            fe_res_d   = '0;
            fe_idx_d   = '0;
        end else if (pop) begin
            cmp_idx_d = sat_inc(cmp_idx_q);
            if (!is_match && !fe_valid_q) begin
                fe_valid_d = 1'b1;
                fe_exp_d   = fifo_rdata;
                fe_res_d   = bus.res_data;
                fe_idx_d   = cmp_idx_q;
            end
        end
    end

    // First-error capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_idx_q  <= '0;
            fe_valid_q <= 1'b0;
            fe_exp_q   <= '0;
            fe_res_q   <= '0;
            fe_idx_q   <= '0;
        end else begin
            cmp_idx_q  <= cmp_idx_d;
            fe_valid_q <= fe_valid_d;
            fe_exp_q   <= fe_exp_d;
            fe_res_q   <= fe_res_d;
            fe_idx_q   <= fe_idx_d;
        end
    end

    assign first_err_exp = fe_exp_q;
    assign first_err_res = fe_res_q;
    assign first_err_idx = fe_idx_q;
`else
    assign first_err_exp = '0;
    assign first_err_res = '0;
    assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_posit_result_checker.sv
// Self-checking bench for posit_result_checker (TOL=1, DEPTH=16, N=32).
// A queue-based reference model predicts the statistics for every result
// beat; a monitor process pops those predictions and compares them.
module tb_posit_result_checker;

    localparam int          N     = 32;
    localparam int          DEPTH = 16;
    localparam int unsigned TOL   = 1;
    localparam logic [31:0] NAR   = 32'h8000_0000;
`ifdef POSIT_CHECK_FIRST_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        clear;
    logic [31:0] match_count;
    logic [31:0] err_count;
    logic [31:0] max_diff;
    logic        mismatch;
    logic        underflow;
    logic        overflow;
    logic        done;
    logic [31:0] first_err_exp;
    logic [31:0] first_err_res;
    logic [31:0] first_err_idx;

    posit_result_checker_if #(.N(N)) bus ();

    posit_result_checker #(
        .N     (N),
        .DEPTH (DEPTH),
        .TOL   (TOL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .clear         (clear),
        .bus           (bus),
        .match_count   (match_count),
        .err_count     (err_count),
        .max_diff      (max_diff),
        .mismatch      (mismatch),
        .underflow     (underflow),
        .overflow      (overflow),
        .done          (done),
        .first_err_exp (first_err_exp),
        .first_err_res (first_err_res),
        .first_err_idx (first_err_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] mc;
        logic [31:0] ec;
        logic [31:0] md;
        logic        mis;
        logic        und;
        logic [31:0] fe;
        logic [31:0] fr;
        logic [31:0] fi;
    } rec_t;

    rec_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [31:0] m_fifo[$];
    longint      m_match, m_err, m_cmp;
    logic [31:0] m_max;
    bit          m_under, m_over, m_mis;
    bit          m_armed, m_draining, m_fin;
    bit          m_fe_seen;
    logic [31:0] m_fe_exp, m_fe_res, m_fe_idx;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic modelReset();
        m_fifo.delete();
        m_match = 0; m_err = 0; m_cmp = 0; m_max = '0;
        m_under = 0; m_over = 0; m_mis = 0;
        m_armed = 0; m_draining = 0; m_fin = 0;
        m_fe_seen = 0; m_fe_exp = '0; m_fe_res = '0; m_fe_idx = '0;
    endtask

    // Predict the effect of one clock edge given this cycle's inputs
    task automatic modelStep(input bit st, input bit sp, input bit cl, input bit ev,
                             input logic [31:0] ed, input bit rv, input logic [31:0] rd);
        int          sz;
        bit          act;
        bit          idle_like;
        logic [31:0] e;
        logic [31:0] d;
        bit          ok;
        rec_t        r;
        sz        = m_fifo.size();
        act       = m_armed || m_draining;
        idle_like = !m_armed && !m_draining;
        m_mis     = 0;
        if (cl) begin
            modelReset();
        end else begin
            if (rv && act && sz > 0) begin
                e = m_fifo.pop_front();
                if (e == NAR || rd == NAR) begin
                    ok = (e == NAR) && (rd == NAR);
                    d  = ok ? 32'h0 : 32'hFFFF_FFFF;
                end else begin
                    d  = (e > rd) ? e - rd : rd - e;
                    ok = (d <= TOL);
                end
                if (ok) begin
                    if (m_match < 64'hFFFF_FFFF) m_match++;
                end else begin
                    if (m_err < 64'hFFFF_FFFF) m_err++;
                    m_mis = 1;
                    if (!m_fe_seen) begin
                        m_fe_seen = 1;
                        m_fe_exp  = e;
                        m_fe_res  = rd;
                        m_fe_idx  = 32'(m_cmp);
                    end
                end
                m_cmp++;
                if (d > m_max) m_max = d;
            end
            if (rv && act && sz == 0) m_under = 1;
            if (ev && m_armed) begin
                if (sz < DEPTH) m_fifo.push_back(ed);
                else            m_over = 1;
            end
            if (idle_like && st) begin
                m_armed = 1; m_fin = 0;
            end else if (m_armed && sp) begin
                m_armed = 0; m_draining = 1;
            end else if (m_draining && sz == 0 && !rv) begin
                m_draining = 0; m_fin = 1;
            end
        end
        if (rv) begin
            r.mc  = 32'(m_match);
            r.ec  = 32'(m_err);
            r.md  = m_max;
            r.mis = m_mis;
            r.und = m_under;
            r.fe  = FE_EN ? m_fe_exp : 32'h0;
            r.fr  = FE_EN ? m_fe_res : 32'h0;
            r.fi  = FE_EN ? m_fe_idx : 32'h0;
            sb_q.push_back(r);
        end
    endtask

    // Drive one cycle of inputs, advance the model, check control outputs
    task automatic applyStimulus(input bit st, input bit sp, input bit cl, input bit ev,
                                 input logic [31:0] ed, input bit rv, input logic [31:0] rd);
        @(negedge clk);
        start = st; stop = sp; clear = cl;
        bus.exp_valid = ev; bus.exp_data = ed;
        bus.res_valid = rv; bus.res_data = rd;
        modelStep(st, sp, cl, ev, ed, rv, rd);
        @(posedge clk);
        #1;
        checkOutput("done", 32'(done), 32'(m_fin));
        checkOutput("exp_ready", 32'(bus.exp_ready), 32'(m_armed && (m_fifo.size() < DEPTH)));
        checkOutput("overflow", 32'(overflow), 32'(m_over));
        checkOutput("underflow", 32'(underflow), 32'(m_under));
        checkOutput("mismatch", 32'(mismatch), 32'(m_mis));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, 0, '0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_match_count"}, match_count, 32'h0);
        checkOutput({tag, "_err_count"}, err_count, 32'h0);
        checkOutput({tag, "_max_diff"}, max_diff, 32'h0);
        checkOutput({tag, "_flags"}, {25'h0, mismatch, underflow, overflow, done, bus.exp_ready, 2'b00}, 32'h0);
        checkOutput({tag, "_fe_exp"}, first_err_exp, 32'h0);
        checkOutput({tag, "_fe_res"}, first_err_res, 32'h0);
        checkOutput({tag, "_fe_idx"}, first_err_idx, 32'h0);
    endtask

    // Scoreboard monitor: each accepted result beat yields one prediction
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            if (bus.res_valid === 1'b1 && rst_n === 1'b1) begin
                #1;
                if (sb_q.size() == 0) begin
                    checkOutput("sb_nonempty", 32'h0, 32'h1);
                end else begin
                    r = sb_q.pop_front();
                    checkOutput("sb_match_count", match_count, r.mc);
                    checkOutput("sb_err_count", err_count, r.ec);
                    checkOutput("sb_max_diff", max_diff, r.md);
                    checkOutput("sb_mismatch", 32'(mismatch), 32'(r.mis));
                    checkOutput("sb_underflow", 32'(underflow), 32'(r.und));
                    checkOutput("sb_fe_exp", first_err_exp, r.fe);
                    checkOutput("sb_fe_res", first_err_res, r.fr);
                    checkOutput("sb_fe_idx", first_err_idx, r.fi);
                end
            end
        end
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL timeout: got running want finished");
        $fatal(1, "[TB] time limit");
    end

    logic [31:0] vals[17];
    logic [31:0] ed, rd;
    bit          st, sp, cl, ev, rv;

    initial begin
        rst_n = 1'b0;
        start = 0; stop = 0; clear = 0;
        bus.exp_valid = 0; bus.exp_data = '0;
        bus.res_valid = 0; bus.res_data = '0;
        modelReset();
        @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Exact results match
        $display("[TB] basic matching run");
        applyStimulus(1, 0, 0, 0, '0, 0, '0);
        applyStimulus(0, 0, 0, 1, 32'h4000_0000, 0, '0);
        applyStimulus(0, 0, 0, 1, 32'h4800_0000, 0, '0);
        idleCycles(3);
        applyStimulus(0, 0, 0, 0, '0, 1, 32'h4000_0000);
        applyStimulus(0, 0, 0, 0, '0, 1, 32'h4800_0000);
        checkOutput("t1_match_count", match_count, 32'd2);
        checkOutput("t1_err_count", err_count, 32'd0);
        checkOutput("t1_max_diff", max_diff, 32'd0);
        applyStimulus(0, 1, 0, 0, '0, 0, '0);
        idleCycles(2);
        checkOutput("t1_done", 32'(done), 32'd1);

        // Tolerance edge and first failure capture
        $display("[TB] tolerance and NaR");
        applyStimulus(0, 0, 1, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, 0, '0, 0, '0);
        applyStimulus(0, 0, 0, 1, 32'h3FFF_FFFF, 0, '0);
        applyStimulus(0, 0, 0, 1, 32'h4000_0000, 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 1, 32'h4000_0000);
        applyStimulus(0, 0, 0, 0, '0, 1, 32'h4000_0003);
        checkOutput("t2_match_count", match_count, 32'd1);
        checkOutput("t2_err_count", err_count, 32'd1);
        checkOutput("t2_max_diff", max_diff, 32'd3);
        checkOutput("t2_fe_idx", first_err_idx, FE_EN ? 32'd1 : 32'd0);
        checkOutput("t2_fe_res", first_err_res, FE_EN ? 32'h4000_0003 : 32'd0);
        applyStimulus(0, 0, 0, 1, NAR, 0, '0);
        applyStimulus(0, 0, 0, 1, NAR, 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 1, 32'h7FFF_FFFF);
        applyStimulus(0, 0, 0, 0, '0, 1, NAR);
        checkOutput("t3_match_count", match_count, 32'd2);
        checkOutput("t3_err_count", err_count, 32'd2);
        checkOutput("t3_max_diff", max_diff, 32'hFFFF_FFFF);
        checkOutput("t3_fe_idx", first_err_idx, FE_EN ? 32'd1 : 32'd0);

        // Fill past depth, then drain
        $display("[TB] fifo full and overflow");
        applyStimulus(0, 0, 1, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, 0, '0, 0, '0);
        for (int i = 0; i < 17; i++) begin
            vals[i] = 32'h4000_0000 + 32'(i * 256);
            applyStimulus(0, 0, 0, 1, vals[i], 0, '0);
            if (i == 15) checkOutput("t4_ready_low", 32'(bus.exp_ready), 32'd0);
        end
        checkOutput("t4_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, '0, 1, vals[i]);
        checkOutput("t4_match_count", match_count, 32'd16);
        checkOutput("t4_ready_high", 32'(bus.exp_ready), 32'd1);

        // Underflow, then clear colliding with a push
        $display("[TB] underflow and clear priority");
        applyStimulus(0, 0, 1, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, 0, '0, 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 1, 32'h1234_5678);
        checkOutput("t5_underflow", 32'(underflow), 32'd1);
        checkOutput("t5_counts", match_count | err_count, 32'd0);
        applyStimulus(0, 0, 1, 1, 32'h5555_0000, 0, '0);
        checkOutput("t5_underflow_clr", 32'(underflow), 32'd0);
        applyStimulus(1, 0, 0, 0, '0, 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 1, 32'h5555_0000);
        checkOutput("t5_fifo_was_empty", 32'(underflow), 32'd1);

        // Asynchronous reset in the middle of a drain
        $display("[TB] reset mid-drain");
        applyStimulus(0, 0, 1, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, 0, '0, 0, '0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 32'h3000_0000 + 32'(i), 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 1, 32'h3000_0000);
        applyStimulus(0, 1, 0, 1, 32'h3000_0005, 0, '0);
        idleCycles(1);
        @(negedge clk);
        start = 0; stop = 0; clear = 0;
        bus.exp_valid = 0; bus.res_valid = 0;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        modelReset();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, '0, 0, '0);
        applyStimulus(0, 0, 0, 1, 32'h4000_0000, 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 1, 32'h4000_0000);
        checkOutput("t6_match_count", match_count, 32'd1);

        // Randomized traffic against the model
        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            st = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 30) == 0);
            cl = ($urandom_range(0, 80) == 0);
            ev = ($urandom_range(0, 1) == 1);
            rv = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0:       ed = NAR;
                1:       ed = 32'h0;
                default: ed = $urandom();
            endcase
            if (m_fifo.size() > 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: rd = m_fifo[0];
                    5, 6:          rd = m_fifo[0] + 32'($urandom_range(0, 3));
                    7:             rd = m_fifo[0] - 32'($urandom_range(1, 2));
                    8:             rd = NAR;
                    default:       rd = $urandom();
                endcase
            end else begin
                rd = $urandom();
            end
            applyStimulus(st, sp, cl, ev, ed, rv, rd);
        end
        idleCycles(3);
        checkOutput("final_match_count", match_count, 32'(m_match));
        checkOutput("final_err_count", err_count, 32'(m_err));
        checkOutput("final_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/posit_result_checker.md
Name: posit_result_checker

Overview:
- Synthesizable scoreboard that sits at the output end of a posit arithmetic pipeline (mult, add, or fused add-of-products, es=2).
- Golden results are pushed in operand order and queued in an internal FIFO. Each pipeline result beat pops one expected value.
- Computes the unsigned absolute bit-pattern difference, applies a tolerance, and keeps pass/fail statistics.
- Replaces file-based error logging for on-FPGA regression; a host reads the counters after a run.

Parameters:
- N, 32, posit width.
- DEPTH, 16, expected-FIFO depth; must be >= pipeline latency + 2; power of two.
- TOL, 0, maximum allowed |expected - result| counted as a match.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms the checker.
- stop  in  1  one-cycle pulse; no further expected values will arrive.
- clear  in  1  synchronous flush of FIFO, counters and flags.
- exp_valid  in  1  expected value valid.
- exp_data  in  N  expected posit.
- exp_ready  out  1  FIFO can accept.
- res_valid  in  1  pipeline done/result valid.
- res_data  in  N  pipeline posit output.
- match_count  out  32  results within tolerance.
- err_count  out  32  results outside tolerance.
- max_diff  out  N  largest diff observed.
- mismatch  out  1  one-cycle pulse per failed compare.
- underflow  out  1  sticky; result arrived with FIFO empty.
- overflow  out  1  sticky; exp_valid while full.
- done  out  1  run finished and drained.
- first_err_exp  out  N  expected value of first failure (feature).
- first_err_res  out  N  result value of first failure (feature).
- first_err_idx  out  32  compare index of first failure (feature).

Behaviour:
- Reset: all outputs 0, except exp_ready=0. FIFO empty; state IDLE.
- States:
  - IDLE: start -> RUN.
  - RUN: stop -> DRAIN.
  - DRAIN: FIFO empty and no res_valid this cycle -> DONE.
  - DONE: start -> RUN; counters keep accumulating unless clear was applied.
- exp_ready = (state==RUN) && !full. Push on exp_valid && exp_ready.
- exp_valid while full in RUN: push dropped, overflow set.
- Pops are accepted in RUN and DRAIN only; res_valid in IDLE/DONE is ignored.
- res_valid with FIFO empty: underflow set, no compare, counters unchanged.
- Simultaneous push and pop:
  - Nonempty FIFO: both occur; occupancy unchanged.
  - Empty FIFO: underflow, push proceeds.
- Compare (registered, 1-cycle latency from res_valid to counter/mismatch update):
  - diff = exp > res ? exp - res : res - exp, in N-bit unsigned arithmetic.
  - NaR (1 followed by N-1 zeros) on either side: match only if both are NaR; otherwise diff = all-ones.
  - Zero is compared like any other pattern.
  - diff <= TOL -> match_count++.
  - Otherwise err_count++ and mismatch pulses.
  - max_diff = max(max_diff, diff).
- Counters saturate at 32'hFFFFFFFF.
- clear: highest priority over push/pop in the same cycle. Empties FIFO; zeros counters, max_diff, sticky flags and captured fields; state -> IDLE. An in-flight registered compare is discarded.
- start while RUN/DRAIN: ignored. stop outside RUN: ignored.
- Asynchronous reset mid-run: immediate return to the reset values.

Optional Feature:
- Macro POSIT_CHECK_FIRST_ERR_EN.
- Defined: on the first failed compare since reset/clear, capture expected value, result and zero-based compare index (counting matches and errors). Later failures do not overwrite.
- Undefined: the three first_err ports are tied to 0; no capture registers are built.

Decomposition:
- posit_defines package: POSIT_NAR_32 constant, checker_state_t enum (IDLE, RUN, DRAIN, DONE), CHECK_CNT_WIDTH=32.
- One sub-module, posit_check_fifo: synchronous FIFO, DEPTH x N, with full/empty, registered pointers and a wrap bit.

Test Plan:
- Start, push 0x40000000, 0x48000000; after 3 cycles, results 0x40000000, 0x48000000 -> match_count=2, err_count=0, max_diff=0; stop -> done=1 after drain.
- TOL=1, expected 0x3FFFFFFF, result 0x40000000 -> match. Expected 0x40000000, result 0x40000003 -> err_count=1, mismatch pulse, max_diff=3. With macro: first_err_idx=1.
- Expected 0x80000000 (NaR), result 0x7FFFFFFF -> error, max_diff=0xFFFFFFFF. NaR vs NaR -> match.
- Push 17 values into DEPTH=16 without results -> exp_ready low after 16; forced exp_valid sets overflow. Sixteen results drain all entries.
- res_valid with FIFO empty in RUN -> underflow=1, counters unchanged. Then clear and push in the same cycle -> FIFO empty, underflow=0, state IDLE.
- rst_n low mid-DRAIN with 5 entries queued -> all outputs 0 immediately. After release, start + one push/result -> match_count=1.
